// File: rtl/handshake_pkg.sv
// Shared definitions for both ends of a handshake link: word layout,
// toggle-bit position and the payload width helper.
package handshake_pkg;

  localparam int unsigned HS_WIDTH   = 32;
  localparam int unsigned HS_TOG_BIT = HS_WIDTH - 1;

  // Request word as driven by the initiator on port1.
  typedef struct packed {
    logic                tog;
    logic [HS_WIDTH-2:0] payload;
  } hs_req_t;

  // Ack word as driven by the responder on port2.
  typedef struct packed {
    logic                tog;
    logic [HS_WIDTH-2:0] count;
  } hs_ack_t;

  // Payload (and ack counter) width for a link of the given word width.
  function automatic int unsigned hs_payload_w(int unsigned width);
    return width - 1;
  endfunction

endpackage

// File: rtl/handshake_if.sv
// Two-signal handshake link. dir1 is the initiator side (drives the request
// word), dir2 is the responder side (drives the ack word).
interface handshake #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] port1;
  logic [WIDTH-1:0] port2;

  modport dir1 (output port1, input  port2);
  modport dir2 (input  port1, output port2);
endinterface

// File: rtl/handshake_fifo.sv
// Small synchronous FIFO. Pointers wrap naturally over a power-of-two
// depth; the level counter is one bit wider so full and empty differ.
module handshake_fifo #(
  parameter int unsigned W     = 31,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic          do_push, do_pop;

  // Overflow/underflow are blocked here as well, so the FIFO stays
  // consistent even if a caller ignores level.
  assign do_push = push && (level != LW'(DEPTH));
  assign do_pop  = pop  && (level != '0);
  assign head    = mem[rp];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage is not reset; reset only moves the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= push_data;
  end

endmodule

// File: rtl/handshake_responder.sv
// Drain end of a handshake link. A request is pending while the incoming
// toggle differs from the last accepted toggle; it is accepted whenever the
// FIFO has room, acked by echoing the toggle, and counted.
module handshake_responder
  import handshake_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  handshake.dir2                   inf,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-2:0]         out_data,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PW  = hs_payload_w(WIDTH);
  localparam int unsigned TB  = WIDTH - 1;
  localparam int unsigned LW  = $clog2(DEPTH) + 1;

  logic          req_seen;
  logic          ack_tog;
  logic [PW-1:0] ack_cnt;
  logic          req_tog;
  logic          full;
  logic          accept;
  logic          pop;

  assign req_tog = inf.port1[TB];
  // Full is judged on the registered level: a same-cycle pop never frees
  // room for a same-cycle push.
  assign full    = (level == LW'(DEPTH));
  assign accept  = (req_tog != req_seen) && !full;
  assign pop     = out_valid && out_ready;

  assign out_valid = (level != '0);
  assign inf.port2 = {ack_tog, ack_cnt};

  // Accept register: remember the toggle, echo it as ack, count the word.
  always_ff @(posedge clk) begin
    if (!rst) begin
      req_seen <= 1'b0;
      ack_tog  <= 1'b0;
      ack_cnt  <= '0;
    end else if (accept) begin
      req_seen <= req_tog;
      ack_tog  <= req_tog;
      ack_cnt  <= ack_cnt + 1'b1;
    end
  end

  handshake_fifo #(
    .W     (PW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (accept),
    .push_data (inf.port1[PW-1:0]),
    .pop       (pop),
    .head      (out_data),
    .level     (level)
  );

endmodule

// File: tb/tb_handshake_responder.sv
// Directed bench for handshake_responder: a queue-based model checked every
// cycle, plus literal expectations at key points and a narrow instance to
// exercise counter wrap.
module tb_handshake_responder;
  import handshake_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        out_ready;
  logic        out_valid;
  logic [30:0] out_data;
  logic [2:0]  level;

  handshake #(.WIDTH(32)) h ();

  handshake_responder #(.WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .inf       (h),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .level     (level)
  );

  // Narrow instance: 4-bit counter, always draining.
  logic       s_ready;
  logic       s_valid;
  logic [3:0] s_data;
  logic [1:0] s_level;

  handshake #(.WIDTH(5)) hs ();

  handshake_responder #(.WIDTH(5), .DEPTH(2)) dut_s (
    .clk       (clk),
    .rst       (rst),
    .inf       (hs),
    .out_valid (s_valid),
    .out_ready (s_ready),
    .out_data  (s_data),
    .level     (s_level)
  );

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h @%0t", name, act, exp, $time);
    end
  endfunction

  // Model: pending/accept/pop rules applied to a plain queue.
  logic        m_seen, m_ack;
  logic [30:0] m_cnt;
  logic [30:0] mq[$];
  bit          started = 0;

  initial forever begin
    @(posedge clk);
    if (rst !== 1'b1) begin
      m_seen = 0; m_ack = 0; m_cnt = 0; mq.delete(); started = 1;
    end else begin
      bit acc, pp;
      acc = (h.port1[31] != m_seen) && (mq.size() < DEPTH);
      pp  = (mq.size() != 0) && out_ready;
      if (pp) void'(mq.pop_front());
      if (acc) begin
        mq.push_back(h.port1[30:0]);
        m_seen = h.port1[31];
        m_ack  = h.port1[31];
        m_cnt  = m_cnt + 31'd1;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (started) begin
      chk("m_port2", h.port2, {m_ack, m_cnt});
      chk("m_out_valid", out_valid, mq.size() != 0);
      chk("m_level", level, mq.size());
      if (mq.size() != 0) chk("m_out_data", out_data, mq[0]);
    end
  end

  // Initiator state.
  logic tog;
  logic stog;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input logic t);
    int n = 0;
    while (h.port2[31] !== t && n < 20) begin tick(); n++; end
    if (h.port2[31] !== t) begin
      errors++;
      $display("FAIL ack_timeout act=%0b exp=%0b @%0t", h.port2[31], t, $time);
    end
  endtask

  task automatic send(input logic [30:0] p);
    hs_req_t r;
    wait_ack(tog);
    tog = ~tog;
    r.tog = tog;
    r.payload = p;
    h.port1 = r;
  endtask

  task automatic s_wait_ack();
    int n = 0;
    while (hs.port2[4] !== stog && n < 20) begin tick(); n++; end
    if (hs.port2[4] !== stog) begin
      errors++;
      $display("FAIL s_ack_timeout act=%0b exp=%0b @%0t", hs.port2[4], stog, $time);
    end
  endtask

  initial begin
    rst = 1'b0; out_ready = 1'b0; s_ready = 1'b1;
    h.port1 = '0; hs.port1 = '0; tog = 0; stog = 0;
    tick(); tick();
    chk("rst_port2", h.port2, 32'h0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_level", level, 3'd0);
    rst = 1'b1;
    repeat (10) tick();
    chk("idle_level", level, 3'd0);
    chk("idle_port2", h.port2, 32'h0);

    // Single request, drained immediately.
    out_ready = 1'b1;
    send(31'h1234);
    tick();
    chk("single_port2", h.port2, 32'h8000_0001);
    chk("single_valid", out_valid, 1'b1);
    chk("single_data", out_data, 31'h1234);
    tick();
    chk("single_level", level, 3'd0);

    // Fill to DEPTH, fifth request must wait.
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send(31'(i));
    wait_ack(tog);
    send(31'd5);
    tick(); tick(); tick();
    chk("full_level", level, 3'd4);
    chk("full_port2", h.port2, {1'b1, 31'd5});
    chk("full_head", out_data, 31'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("full_pop_level", level, 3'd3);
    tick();
    chk("fifth_port2", h.port2, {1'b0, 31'd6});
    chk("fifth_level", level, 3'd4);
    out_ready = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      chk("order", out_data, 31'(k));
      tick();
    end
    out_ready = 1'b0;
    chk("drained", level, 3'd0);

    // Simultaneous push and pop at level 2.
    send(31'd10);
    send(31'd11);
    wait_ack(tog);
    chk("pp_pre_level", level, 3'd2);
    send(31'd12);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("pp_level", level, 3'd2);
    chk("pp_cnt", h.port2[30:0], 31'd9);
    chk("pp_head", out_data, 31'd11);

    // Reset with three buffered and one pending.
    send(31'd13);
    wait_ack(tog);
    chk("mid_level", level, 3'd3);
    tog = ~tog;
    h.port1 = {tog, 31'd14};
    rst = 1'b0;
    tick();
    chk("mid_rst_port2", h.port2, 32'h0);
    chk("mid_rst_level", level, 3'd0);
    chk("mid_rst_valid", out_valid, 1'b0);
    h.port1 = '0; tog = 0;
    tick();
    rst = 1'b1;
    repeat (10) tick();
    chk("post_rst_level", level, 3'd0);
    chk("post_rst_port2", h.port2, 32'h0);

    // Counter wrap on the narrow instance: 16 accepts on a 4-bit counter.
    for (int i = 0; i < 15; i++) begin
      s_wait_ack();
      stog = ~stog;
      hs.port1 = {stog, 4'(i)};
    end
    s_wait_ack();
    chk("s_cnt15", hs.port2, {1'b1, 4'hF});
    stog = ~stog;
    hs.port1 = {stog, 4'hA};
    tick();
    chk("s_wrap", hs.port2, {1'b0, 4'h0});
    chk("s_data", s_data, 4'hA);
    tick();
    chk("s_level", s_level, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
